v2k_typedef_yee_pixel_pipe: RTL and testbench

Parametrised elastic pixel stage: the successor to the single-register pixel stage in the `v2k_typedef_yee` sub-block chain. It carries pixels of `CHANNELS` × `CH_WIDTH` bits through a `DEPTH`-entry buffer with valid/ready handshakes on both sides. Per-pixel channel-order swap, line-length measurement, and a synchronous flush are added. It sits between sub1 and sub2 and absorbs back-pressure from sub2.

---
 rtl/v2k_typedef_yee_pixel_pipe.sv | 137 +++++++++++++
 tb/tb_v2k_typedef_yee_pixel_pipe.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/v2k_typedef_yee_pixel_pipe.sv
// Elastic pixel stage: DEPTH-entry register FIFO with valid/ready on both sides,
// per-pixel channel reversal at write, line-length measurement and stall watchdog.
module v2k_typedef_yee_pixel_pipe #(
  parameter int CH_WIDTH = 8,
  parameter int CHANNELS = 3,
  parameter int DEPTH    = 4,
  localparam int PW      = CHANNELS * CH_WIDTH,
  localparam int LW      = $clog2(DEPTH + 1),
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          cp,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_pixel,
  input  logic          in_last,
  input  logic          swap_en,
  input  logic          clear,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_pixel,
  output logic          out_last,
  output logic [LW-1:0] level,
  output logic [15:0]   line_len,
  output logic          line_done,
  output logic          overflow
);

  function automatic logic [PW-1:0] swap_ch(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      r[k*CH_WIDTH +: CH_WIDTH] = p[(CHANNELS-1-k)*CH_WIDTH +: CH_WIDTH];
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PW:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic [15:0]   cnt;
  logic [7:0]    stall_cnt;
  logic          push;
  logic          pop;
  logic [PW:0]   head;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Write stage: data storage carries no reset; swap is folded in here.
  always_ff @(posedge cp) begin
    if (push && !clear) begin
      mem[wr_ptr] <= {in_last, swap_en ? swap_ch(in_pixel) : in_pixel};
    end
  end

  // Occupancy and handshake flags are registered from the next level.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level     <= level_nxt;
      in_ready  <= (level_nxt != LW'(DEPTH));
      out_valid <= (level_nxt != '0);
    end
  end

  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      line_len  <= '0;
      line_done <= 1'b0;
    end else if (clear) begin
      cnt       <= '0;
      line_done <= 1'b0;
    end else begin
      line_done <= 1'b0;
      if (push) begin
        if (in_last) begin
          line_len  <= sat_inc16(cnt);
          line_done <= 1'b1;
          cnt       <= '0;
        end else begin
          cnt <= sat_inc16(cnt);
        end
      end
    end
  end

  // Watchdog: overflow latches once the stall outlasts 255 cycles.
  always_ff @(posedge cp or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else if (clear) begin
      stall_cnt <= '0;
      overflow  <= 1'b0;
    end else if (in_valid && !in_ready) begin
      if (stall_cnt == 8'hFF) overflow <= 1'b1;
      else                    stall_cnt <= stall_cnt + 8'd1;
    end else begin
      stall_cnt <= '0;
    end
  end

  // Read stage: head is gated so reset and empty present zeros, never stale data.
  assign head      = mem[rd_ptr];
  assign out_pixel = out_valid ? head[PW-1:0] : '0;
  assign out_last  = out_valid ? head[PW]     : 1'b0;

endmodule

// File: tb/tb_v2k_typedef_yee_pixel_pipe.sv
// Directed bench for v2k_typedef_yee_pixel_pipe: vector table plus hand-written
// sequences for line length, overflow, clear, async reset and a scoreboarded run.
module tb_v2k_typedef_yee_pixel_pipe;

  logic        cp = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_pixel;
  logic        in_last;
  logic        swap_en;
  logic        clear;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_pixel;
  logic        out_last;
  logic [2:0]  level;
  logic [15:0] line_len;
  logic        line_done;
  logic        overflow;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 cp = ~cp;

  v2k_typedef_yee_pixel_pipe #(.CH_WIDTH(8), .CHANNELS(3), .DEPTH(4)) dut (
    .cp(cp), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_last(in_last), .swap_en(swap_en), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_last(out_last), .level(level), .line_len(line_len),
    .line_done(line_done), .overflow(overflow)
  );

  typedef struct {
    logic        iv;
    logic [23:0] px;
    logic        last;
    logic        sw;
    logic        ordy;
    logic        clr;
    logic        e_ir;
    logic        e_ov;
    logic [2:0]  e_lvl;
    logic [23:0] e_px;
    logic        e_last;
    logic        e_ld;
    logic [15:0] e_len;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [23:0] px, logic last, logic sw,
                              logic ordy, logic clr, logic e_ir, logic e_ov,
                              logic [2:0] e_lvl, logic [23:0] e_px, logic e_last,
                              logic e_ld, logic [15:0] e_len);
    vec_t v;
    v.iv = iv; v.px = px; v.last = last; v.sw = sw; v.ordy = ordy; v.clr = clr;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_lvl = e_lvl; v.e_px = e_px;
    v.e_last = e_last; v.e_ld = e_ld; v.e_len = e_len;
    return v;
  endfunction

  function automatic logic [23:0] rev3(input logic [23:0] p);
    return {p[7:0], p[15:8], p[23:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ld_seen;
    logic [23:0] q[$];
    logic [23:0] exp_px;
    int          sent, got, cyc;

    reset = 1'b0; in_valid = 1'b0; in_pixel = '0; in_last = 1'b0;
    swap_en = 1'b0; clear = 1'b0; out_ready = 1'b0;

    // Table: push/pop, swap, fill to full, back-pressure, clear discarding a push
    vecs.push_back(mk(1, 24'h112233, 0, 0, 1, 0,  1, 1, 1, 24'h112233, 0, 0, 16'd0));
    vecs.push_back(mk(1, 24'h445566, 1, 1, 1, 0,  1, 1, 1, 24'h665544, 1, 1, 16'd2));
    vecs.push_back(mk(0, 24'h000000, 0, 0, 1, 0,  1, 0, 0, 24'h000000, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h0A0B0C, 0, 0, 0, 0,  1, 1, 1, 24'h0A0B0C, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h010203, 0, 0, 0, 0,  1, 1, 2, 24'h0A0B0C, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h040506, 0, 0, 0, 0,  1, 1, 3, 24'h0A0B0C, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h070809, 0, 1, 0, 0,  0, 1, 4, 24'h0A0B0C, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h0D0E0F, 0, 0, 0, 0,  0, 1, 4, 24'h0A0B0C, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h0D0E0F, 0, 0, 1, 0,  1, 1, 3, 24'h010203, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h0D0E0F, 0, 0, 0, 0,  0, 1, 4, 24'h010203, 0, 0, 16'd2));
    vecs.push_back(mk(0, 24'h000000, 0, 0, 1, 0,  1, 1, 3, 24'h040506, 0, 0, 16'd2));
    vecs.push_back(mk(0, 24'h000000, 0, 0, 1, 0,  1, 1, 2, 24'h090807, 0, 0, 16'd2));
    vecs.push_back(mk(0, 24'h000000, 0, 0, 1, 0,  1, 1, 1, 24'h0D0E0F, 0, 0, 16'd2));
    vecs.push_back(mk(0, 24'h000000, 0, 0, 1, 0,  1, 0, 0, 24'h000000, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h111111, 0, 0, 0, 0,  1, 1, 1, 24'h111111, 0, 0, 16'd2));
    vecs.push_back(mk(1, 24'h222222, 1, 0, 1, 1,  1, 0, 0, 24'h000000, 0, 0, 16'd2));
    vecs.push_back(mk(0, 24'h000000, 0, 0, 0, 0,  1, 0, 0, 24'h000000, 0, 0, 16'd2));

    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_line_len", line_len, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_last", out_last, 0);

    @(negedge cp);
    reset = 1'b1;
    tick();
    chk("rel_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_pixel = vecs[i].px; in_last = vecs[i].last;
      swap_en = vecs[i].sw; out_ready = vecs[i].ordy; clear = vecs[i].clr;
      tick();
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("v%0d_level", i), level, vecs[i].e_lvl);
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_out_pixel", i), out_pixel, vecs[i].e_px);
        chk($sformatf("v%0d_out_last", i), out_last, vecs[i].e_last);
      end
      chk($sformatf("v%0d_line_done", i), line_done, vecs[i].e_ld);
      chk($sformatf("v%0d_line_len", i), line_len, vecs[i].e_len);
    end
    in_valid = 1'b0; in_last = 1'b0; swap_en = 1'b0; clear = 1'b0;

    // 640-pixel line then a 3-pixel line
    ld_seen = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 640; i++) begin
      in_valid = 1'b1; in_pixel = 24'(i); in_last = (i == 639);
      if (!in_ready) chk("line640_in_ready", in_ready, 1);
      tick();
      if (i < 639) ld_seen = ld_seen | line_done;
    end
    chk("line640_early_done", ld_seen, 0);
    chk("line640_done", line_done, 1);
    chk("line640_len", line_len, 16'd640);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("line640_done_pulse", line_done, 0);
    chk("line640_len_hold", line_len, 16'd640);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pixel = 24'hABC000 + 24'(i); in_last = (i == 2);
      tick();
    end
    chk("line3_done", line_done, 1);
    chk("line3_len", line_len, 16'd3);
    in_valid = 1'b0; in_last = 1'b0;
    tick(); tick();
    chk("line3_drained", level, 0);

    // Overflow: fill, then hold in_valid through 256 stalled cycles
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_pixel = 24'h300000 + 24'(i);
      tick();
    end
    chk("ovf_full_ready", in_ready, 0);
    chk("ovf_full_level", level, 4);
    for (int i = 0; i < 255; i++) tick();
    chk("ovf_at_255", overflow, 0);
    tick();
    chk("ovf_at_256", overflow, 1);
    in_valid = 1'b0;
    tick(); tick(); tick();
    chk("ovf_sticky", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_overflow", overflow, 0);
    chk("clr_level", level, 0);
    chk("clr_in_ready", in_ready, 1);
    chk("clr_out_valid", out_valid, 0);

    // Asynchronous reset with three pixels buffered
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pixel = 24'h500000 + 24'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("arst_pre_level", level, 3);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_level", level, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_pixel", out_pixel, 0);
    @(negedge cp);
    reset = 1'b1;
    tick();
    chk("arst_rel_in_ready", in_ready, 1);
    chk("arst_rel_out_valid", out_valid, 0);
    chk("arst_rel_level", level, 0);
    in_valid = 1'b1; in_pixel = 24'hABCDEF;
    tick();
    in_valid = 1'b0;
    chk("arst_fresh_valid", out_valid, 1);
    chk("arst_fresh_pixel", out_pixel, 24'hABCDEF);
    out_ready = 1'b1;
    tick();
    chk("arst_fresh_drained", level, 0);

    // Random valid/ready with scoreboard
    sent = 0; got = 0; cyc = 0;
    while (got < 300 && cyc < 5000) begin
      in_valid  = (sent < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_pixel  = 24'($urandom());
      swap_en   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (in_valid && in_ready) begin
        q.push_back(swap_en ? rev3(in_pixel) : in_pixel);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_spurious_pop", 1, 0);
        end else begin
          exp_px = q.pop_front();
          chk("rnd_pixel", out_pixel, exp_px);
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_received", got, 300);
    chk("rnd_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
